// File: rtl/camera_pkg.sv
// Shared types and helpers for the camera capture path: FSM states, default
// QCIF geometry, RGB332 colour constants and the RGB565 -> RGB332 packer.
package camera_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    ACTIVE  = 2'd2
  } state_t;

  localparam int IMG_WIDTH_DEF  = 176;
  localparam int IMG_HEIGHT_DEF = 144;

  localparam logic [7:0] RGB332_RED   = 8'hE0;
  localparam logic [7:0] RGB332_GREEN = 8'h1C;
  localparam logic [7:0] RGB332_BLUE  = 8'h03;
  localparam logic [7:0] RGB332_BLACK = 8'h00;
  localparam logic [7:0] RGB332_WHITE = 8'hFF;

  // hi = {R[4:0], G[5:3]}, lo = {G[2:0], B[4:0]}; keep the top bits of each channel.
  function automatic logic [7:0] rgb565_to_rgb332(input logic [7:0] hi, input logic [7:0] lo);
    return {hi[7:5], hi[2:0], lo[4:3]};
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Registers one camera control line and flags its rising/falling edges
// relative to the previous registered sample.
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic prev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q        <= 1'b0;
      prev_reg <= 1'b0;
    end else begin
      q        <= d;
      prev_reg <= q;
    end
  end

  assign rise = q & ~prev_reg;
  assign fall = ~q & prev_reg;

endmodule

// File: rtl/camera_capture.sv
// OV7670-style RGB565 byte stream capture into an RGB332 frame-buffer write port.
// Frame-aligned on VSYNC, line-counted on HREF, two bytes packed per pixel.
module camera_capture
  import camera_pkg::*;
#(
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter int ADDR_W     = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              capture_en,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  output logic [7:0]        pixel_out,
  output logic [ADDR_W-1:0] w_addr,
  output logic              w_en,
  output logic              frame_done,
  output logic              sync_err
);

  localparam int XW = $clog2(IMG_WIDTH + 1);
  localparam int YW = $clog2(IMG_HEIGHT + 1);
  localparam logic [XW-1:0]     X_LIM     = XW'(IMG_WIDTH);
  localparam logic [YW-1:0]     Y_LIM     = YW'(IMG_HEIGHT);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(IMG_WIDTH);

  state_t state_reg, state_next;

  logic              vs_q, vs_rise, vs_fall;
  logic              href_q, href_rise, href_fall;
  logic [7:0]        data_q, b0_reg;
  logic              cap_en_q, phase_reg;
  logic [XW-1:0]     x_reg;
  logic [YW-1:0]     y_reg, y_line;
  logic [ADDR_W-1:0] ptr_reg, base_reg;
  logic              start, pack, line_end, in_bounds;

  sync_edge_det u_vsync (.clk(clk), .rst_n(reset_n), .d(cam_vsync),
                         .q(vs_q), .rise(vs_rise), .fall(vs_fall));
  sync_edge_det u_href  (.clk(clk), .rst_n(reset_n), .d(cam_href),
                         .q(href_q), .rise(href_rise), .fall(href_fall));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    case (state_reg)
      IDLE:    if (vs_rise) state_next = WAIT_VS;
      WAIT_VS: if (vs_fall && cap_en_q) begin
                 state_next = ACTIVE;
                 start      = 1'b1;
               end
      ACTIVE:  if (vs_rise) state_next = WAIT_VS;
      default: state_next = IDLE;
    endcase
  end

  // Line end is folded into the row count before the frame-end test, so a
  // simultaneous HREF fall and VSYNC rise still counts the last line.
  always_comb begin
    pack      = (state_reg == ACTIVE) && href_q && !vs_q;
    line_end  = (state_reg == ACTIVE) && href_fall;
    in_bounds = (x_reg < X_LIM) && (y_reg < Y_LIM);
    y_line    = (line_end && (y_reg < Y_LIM)) ? y_reg + 1'b1 : y_reg;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q     <= 8'h00;
      cap_en_q   <= 1'b0;
      b0_reg     <= 8'h00;
      phase_reg  <= 1'b0;
      x_reg      <= '0;
      y_reg      <= '0;
      ptr_reg    <= '0;
      base_reg   <= '0;
      pixel_out  <= 8'h00;
      w_addr     <= '0;
      w_en       <= 1'b0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      data_q     <= cam_data;
      cap_en_q   <= capture_en;
      w_en       <= 1'b0;
      frame_done <= 1'b0;
      if (start) begin
        phase_reg <= 1'b0;
        x_reg     <= '0;
        y_reg     <= '0;
        ptr_reg   <= '0;
        base_reg  <= '0;
      end else if (state_reg == ACTIVE) begin
        if (href_rise) ptr_reg <= base_reg;
        if (pack) begin
          phase_reg <= ~phase_reg;
          if (!phase_reg) begin
            b0_reg <= data_q;
          end else if (in_bounds) begin
            pixel_out <= rgb565_to_rgb332(b0_reg, data_q);
            w_addr    <= ptr_reg;
            w_en      <= 1'b1;
            ptr_reg   <= ptr_reg + 1'b1;
            x_reg     <= x_reg + 1'b1;
          end
        end
        if (line_end) begin
          x_reg     <= '0;
          phase_reg <= 1'b0;
          // odd trailing byte, or a line that left pixels unwritten
          if (phase_reg || in_bounds) sync_err <= 1'b1;
          if (y_reg < Y_LIM) begin
            y_reg    <= y_reg + 1'b1;
            base_reg <= base_reg + LINE_STEP;
          end
        end
        if (vs_rise) begin
          if (y_line == Y_LIM) frame_done <= 1'b1;
          else                 sync_err   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_camera_capture.sv
// Self-checking bench for camera_capture: byte-level camera stimulus against a
// line/frame-level reference model of expected frame-buffer writes.
module tb_camera_capture;

  localparam int W = 176;
  localparam int H = 144;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        capture_en = 1'b0;
  logic        cam_vsync = 1'b0;
  logic        cam_href = 1'b0;
  logic [7:0]  cam_data = 8'h00;
  logic [7:0]  pixel_out;
  logic [14:0] w_addr;
  logic        w_en, frame_done, sync_err;

  camera_capture #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_W(15)) dut (
    .clk(clk), .reset_n(reset_n), .capture_en(capture_en),
    .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
    .pixel_out(pixel_out), .w_addr(w_addr), .w_en(w_en),
    .frame_done(frame_done), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [14:0] addr; logic [7:0] pix;} wr_t;
  typedef struct {logic [15:0] px; logic [7:0] exp;} vec_t;

  wr_t        got_q[$];
  wr_t        exp_q[$];
  logic [7:0] got_pix [0:32767];
  int         got_cyc [0:32767];
  logic [15:0] line_px [0:199];
  vec_t       tv [0:5];

  int cyc = 0, done_cnt = 0, errors = 0, checks = 0, b1_cyc = 0;
  int m_y = 0, m_done = 0;
  bit m_active = 1'b0, m_armed = 1'b0, m_err = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    wr_t e;
    if (w_en) begin
      e = {w_addr, pixel_out};
      got_q.push_back(e);
      got_pix[w_addr] = pixel_out;
      got_cyc[w_addr] = cyc;
    end
    if (frame_done) done_cnt++;
  end

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation time limit reached, got=running required=finished");
    $fatal(1, "watchdog");
  end

  // Reference colour reduction from RGB565 channel fields.
  function automatic logic [7:0] ref332(input logic [15:0] p);
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
    r = p[15:11];
    g = p[10:5];
    b = p[4:0];
    return {r[4:2], g[5:3], b[4:3]};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h required=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 200; i++) line_px[i] = 16'($urandom);
  endtask

  task automatic fill_fixed(input logic [15:0] v);
    for (int i = 0; i < 200; i++) line_px[i] = v;
  endtask

  // Drives one HREF line of nbytes from line_px and updates the model.
  task automatic send_line(input int nbytes);
    int npx, a;
    wr_t e;
    cam_href = 1'b1;
    for (int b = 0; b < nbytes; b++) begin
      cam_data = (b % 2 == 0) ? line_px[b/2][15:8] : line_px[b/2][7:0];
      if (b == 1) b1_cyc = cyc;
      tick();
    end
    cam_href = 1'b0;
    cam_data = 8'h00;
    tick();
    tick();
    if (m_active) begin
      npx = nbytes / 2;
      for (int k = 0; k < npx; k++) begin
        if (k < W && m_y < H) begin
          a = m_y * W + k;
          e = {a[14:0], ref332(line_px[k])};
          exp_q.push_back(e);
        end
      end
      if (nbytes % 2 == 1) m_err = 1'b1;
      if (m_y < H && npx < W) m_err = 1'b1;
      if (m_y < H) m_y++;
    end
  endtask

  task automatic vsync_pulse(input bit cap);
    capture_en = cap;
    cam_vsync = 1'b1;
    repeat (3) tick();
    if (m_active) begin
      if (m_y == H) m_done++;
      else m_err = 1'b1;
      m_active = 1'b0;
    end
    m_armed = 1'b1;
    cam_vsync = 1'b0;
    repeat (3) tick();
    if (m_armed && cap) begin
      m_active = 1'b1;
      m_y = 0;
    end
  endtask

  task automatic check_stream(input string name);
    int nbad = 0, first = -1, n;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    check({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < n; i++) begin
      if (got_q[i] != exp_q[i]) begin
        if (first < 0) first = i;
        nbad++;
      end
    end
    if (nbad > 0)
      $display("note %s first differing write #%0d: got addr=%0d pix=%h want addr=%0d pix=%h",
               name, first, got_q[first].addr, got_q[first].pix, exp_q[first].addr, exp_q[first].pix);
    check({name, "_data_mismatches"}, nbad, 0);
    $display("%s: %0d writes compared, %0d expected", name, n, exp_q.size());
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    tv[0] = '{16'h07E0, 8'h1C};
    tv[1] = '{16'hF800, 8'hE0};
    tv[2] = '{16'h001F, 8'h03};
    tv[3] = '{16'h0000, 8'h00};
    tv[4] = '{16'hFFFF, 8'hFF};
    tv[5] = '{16'h8410, 8'h92};

    // reset state
    repeat (3) tick();
    check("rst_outputs_in_reset", {pixel_out, w_addr, w_en, frame_done, sync_err}, 0);
    reset_n = 1'b1;
    repeat (2) tick();
    check("rst_outputs_after_release", {pixel_out, w_addr, w_en, frame_done, sync_err}, 0);

    // full frame of pure red
    vsync_pulse(1'b1);
    fill_fixed(16'hF800);
    for (int l = 0; l < H; l++) send_line(2 * W);
    vsync_pulse(1'b1);
    check("f1_frame_done", done_cnt, m_done);
    check("f1_sync_err", sync_err, m_err);
    check_stream("f1");

    // table-driven first pixels, latency, long line, odd line, early VSYNC
    for (int l = 0; l < 3; l++) begin
      fill_rand();
      send_line(2 * W);
    end
    fill_rand();
    line_px[0] = tv[0].px;
    send_line(2 * W);
    check("f2_latency_b1_to_wen", got_cyc[3*W] - b1_cyc, 2);
    fill_rand();
    send_line(2 * 181);
    check("f2_long_line_no_err", sync_err, m_err);
    for (int i = 1; i < 6; i++) begin
      fill_rand();
      line_px[0] = tv[i].px;
      send_line(2 * W);
    end
    for (int i = 0; i < 6; i++) begin
      int a;
      a = (i == 0) ? 3 * W : (i + 4) * W;
      check($sformatf("vec%0d_pixel", i), got_pix[a], tv[i].exp);
      $display("vec %0d px=%h addr=%0d pixel=%h expect=%h", i, tv[i].px, a, got_pix[a], tv[i].exp);
    end
    fill_rand();
    send_line(3);
    check("f2_odd_byte_err", sync_err, 1'b1);
    fill_rand();
    send_line(2 * W);
    while (m_y < 100) begin
      fill_rand();
      send_line(4);
    end
    vsync_pulse(1'b1);
    check("f2_early_vsync_no_done", done_cnt, m_done);
    check("f2_early_vsync_err", sync_err, 1'b1);
    check_stream("f2");

    // next frame completes with addresses restarting at 0
    for (int l = 0; l < H; l++) begin
      fill_rand();
      send_line(4);
    end
    vsync_pulse(1'b1);
    check("f3_frame_done", done_cnt, m_done);
    check("f3_first_addr", (got_q.size() > 0) ? got_q[0].addr : 15'h7FFF, 0);
    check_stream("f3");

    // reset mid-line, then IDLE and disabled frames must not write
    fill_rand();
    cam_href = 1'b1;
    for (int b = 0; b < 5; b++) begin
      cam_data = 8'($urandom);
      tick();
    end
    reset_n = 1'b0;
    #2;
    check("t6_outputs_on_reset", {pixel_out, w_addr, w_en, frame_done, sync_err}, 0);
    m_active = 1'b0;
    m_armed = 1'b0;
    m_err = 1'b0;
    m_y = 0;
    cam_href = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (2) tick();
    got_q.delete();
    exp_q.delete();
    for (int l = 0; l < 2; l++) begin
      fill_rand();
      send_line(8);
    end
    vsync_pulse(1'b0);
    for (int l = 0; l < 2; l++) begin
      fill_rand();
      send_line(8);
    end
    check("t6_no_err", sync_err, m_err);
    check_stream("t6_idle");
    vsync_pulse(1'b1);
    for (int l = 0; l < 2; l++) begin
      fill_rand();
      send_line(4);
    end
    check_stream("t6_resume");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
